// File: rtl/phy_pkg.sv
// Shared definitions for the single-clock TX lane serializer: link states,
// the default comma symbol and an index-width helper.
package phy_pkg;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_LINK_WAIT = 2'd1,
    ST_RUN       = 2'd2
  } link_state_e;

  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

  // Width of an index into n items; a single item still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phy_rr_arbiter.sv
// Lane arbiter: turns the round-robin pointer and the lane valid vector into a
// one-hot grant, its encoded index and the pointer to use after a grant.
module phy_rr_arbiter
  import phy_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int SKIP_MODE = 1,
  parameter int PTR_W     = idx_width(LANES)
) (
  input  logic [PTR_W-1:0] rr_ptr,
  input  logic [LANES-1:0] valid,
  output logic [LANES-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any,
  output logic [PTR_W-1:0] next_ptr
);

  always_comb begin
    int   base;
    int   lane;
    logic found;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    next_ptr  = rr_ptr;
    found     = 1'b0;
    lane      = 0;
    base      = int'(rr_ptr);
    if (SKIP_MODE != 0) begin
      // Work-conserving: first valid lane at or after the pointer wins.
      for (int i = 0; i < LANES; i++) begin
        lane = (base + i) % LANES;
        if (!found && valid[lane]) begin
          found           = 1'b1;
          grant[lane]     = 1'b1;
          grant_idx       = PTR_W'(lane);
          next_ptr        = PTR_W'((lane + 1) % LANES);
        end
      end
      grant_any = found;
    end else begin
      lane     = base % LANES;
      next_ptr = PTR_W'((lane + 1) % LANES);
      if (valid[lane]) begin
        grant[lane] = 1'b1;
        grant_idx   = PTR_W'(lane);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phy_tx_lane_serializer.sv
// Single-clock TX lane serializer: arbitrates byte lanes, shifts symbols out
// MSB-first one bit per clock and runs the INIT/LINK_WAIT/RUN bring-up.
module phy_tx_lane_serializer
  import phy_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                LANES     = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM  = DATA_W'(IDLE_SYM_DEFAULT),
  parameter int                INIT_IDLE = 4,
  parameter int                SKIP_MODE = 1,
  localparam int               LANE_W    = idx_width(LANES)
) (
  input  logic                    clk_32f,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_valid,
  output logic [LANES-1:0]        in_ready,
  input  logic                    rx_active,
  output logic                    serial_out,
  output logic                    sym_start,
  output logic                    cur_is_data,
  output logic [LANE_W-1:0]       cur_lane,
  output logic                    link_up
);

  localparam int                 CNT_W     = idx_width(DATA_W);
  localparam int                 IDLE_W    = idx_width(INIT_IDLE + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [IDLE_W-1:0]  LAST_IDLE = IDLE_W'(INIT_IDLE - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  link_state_e       state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              cur_is_data_q, cur_is_data_d;
  logic [LANE_W-1:0] cur_lane_q, cur_lane_d;
  logic              sym_start_q, sym_start_d;
  logic              link_up_q, link_up_d;

  logic              boundary;
  logic              eligible;
  logic [LANES-1:0]  grant;
  logic [LANE_W-1:0] grant_idx;
  logic [LANE_W-1:0] next_ptr;
  logic              grant_any;
  logic [DATA_W-1:0] lane_word;

  phy_rr_arbiter #(
    .LANES    (LANES),
    .SKIP_MODE(SKIP_MODE),
    .PTR_W    (LANE_W)
  ) u_arb (
    .rr_ptr   (rr_ptr_q),
    .valid    (in_valid),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any),
    .next_ptr (next_ptr)
  );

  assign boundary = (bit_cnt_q == LAST_BIT);
  assign eligible = boundary && (state_d == ST_RUN);
  assign in_ready = eligible ? grant : '0;

  always_comb begin
    lane_word = IDLE_SYM;
    for (int i = 0; i < LANES; i++) begin
      if (grant[i]) lane_word = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Link state only moves at symbol boundaries; the symbol in flight always completes.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    if (boundary) begin
      unique case (state_q)
        ST_INIT: begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          if (idle_cnt_q == LAST_IDLE) state_d = rx_active ? ST_RUN : ST_LINK_WAIT;
        end
        ST_LINK_WAIT: if (rx_active) state_d = ST_RUN;
        ST_RUN:       if (!rx_active) state_d = ST_LINK_WAIT;
        default:      state_d = ST_INIT;
      endcase
    end
  end

  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    cur_is_data_d = cur_is_data_q;
    cur_lane_d    = cur_lane_q;
    if (!boundary) begin
      shift_d   = {shift_q[DATA_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end else begin
      bit_cnt_d     = '0;
      shift_d       = IDLE_SYM;
      cur_is_data_d = 1'b0;
      cur_lane_d    = '0;
      if (eligible) begin
        rr_ptr_d = next_ptr;
        if (grant_any) begin
          shift_d       = lane_word;
          cur_is_data_d = 1'b1;
          cur_lane_d    = grant_idx;
        end
      end
    end
    sym_start_d = (bit_cnt_d == '0);
    link_up_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shift_q       <= IDLE_SYM;
      bit_cnt_q     <= '0;
      state_q       <= ST_INIT;
      idle_cnt_q    <= '0;
      rr_ptr_q      <= '0;
      cur_is_data_q <= 1'b0;
      cur_lane_q    <= '0;
      sym_start_q   <= 1'b1;
      link_up_q     <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_is_data_q <= cur_is_data_d;
      cur_lane_q    <= cur_lane_d;
      sym_start_q   <= sym_start_d;
      link_up_q     <= link_up_d;
    end
  end

  assign serial_out  = shift_q[DATA_W-1];
  assign sym_start   = sym_start_q;
  assign cur_is_data = cur_is_data_q;
  assign cur_lane    = cur_lane_q;
  assign link_up     = link_up_q;

endmodule
